spi_master_px: RTL and testbench
================================

Name: spi_master_px

Overview:
- Parametrised successor to the byte-wide SPI master.
- Supports:
  - configurable word width
  - runtime SPI mode (CPOL/CPHA)
  - MSB- or LSB-first shifting
  - programmable SCLK divider
  - multiple one-hot-decoded slave selects
  - a start/busy/done handshake
- Sits between the CPU peripheral bus and off-chip SPI flash/peripherals; one transfer in flight at a time.

Parameters:
- DATA_W, 8, word width in bits (2..32).
- NUM_SS, 4, number of slave-select outputs (1..16).
- SS_W, 2, width of ss_sel; must satisfy 2**SS_W >= NUM_SS.
- DIV_W, 8, width of clk_div.

Ports:
- clock_in  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request transfer; accepted only when busy=0.
- datain  input  DATA_W  word to transmit; captured on accepted start.
- ss_sel  input  SS_W  slave index; captured on accepted start.
- cpol  input  1  SCLK idle level; captured on accepted start.
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge. Captured on start.
- lsb_first  input  1  shift order; captured on start.
- clk_div  input  DIV_W  SCLK half-period = clk_div+1 clock_in cycles; captured on start.
- miso  input  1  serial data in.
- dataout  output  DATA_W  last received word.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.
- sclk  output  1  SPI clock.
- mosi  output  1  serial data out.
- ssn  output  NUM_SS  active-low slave selects.

Behaviour:
- Reset (reset_n=0, async): state=IDLE.
  - sclk=0, mosi=0, ssn=all 1, dataout=0, busy=0, done=0.
  - All counters and shadow registers cleared.
- Define H = clk_div+1 (captured value).
- IDLE:
  - sclk is registered from the live cpol input every cycle.
  - start=1 captures datain, ss_sel, cpol, cpha, lsb_first and clk_div.
  - Then transitions to SETUP; busy=1 from the next cycle.
- SETUP (H cycles):
  - ssn[ss_sel]=0. If ss_sel >= NUM_SS, no ssn asserts, but the transfer still runs.
  - mosi = first bit (MSB, or LSB if lsb_first).
  - sclk held at cpol.
- XFER (2*DATA_W*H cycles):
  - sclk toggles every H cycles, giving 2*DATA_W edges; edge 1 is the leading edge.
  - CPHA=0: sample miso on odd edges; shift mosi on even edges, except after the final edge.
  - CPHA=1: shift on odd edges, except edge 1, which keeps the pre-driven first bit; sample on even edges.
  - Received bits enter the shift register at the end opposite to the transmit end (MSB-first: in at bit 0).
- HOLD (H cycles):
  - sclk=cpol, ssn still asserted.
- Completion:
  - In the cycle after HOLD: ssn=all 1, dataout <= shift register, done=1 for exactly one cycle, busy=0, state=IDLE.
  - Total latency from the accepted start edge to done is (2*DATA_W+2)*H+1 cycles.
  - A new start may be accepted in the same cycle done is high; that start captures the new word.
- start while busy=1 is ignored: no queueing, captured values unchanged.
- Input changes mid-transfer (mode, divider, datain) have no effect until the next start.
- dataout holds its value between transfers; it is updated only at done.
- clk_div=0 gives H=1: sclk = clock_in/2, no stall cycles.
- Counter widths:
  - half-period counter: DIV_W bits.
  - edge counter: $clog2(2*DATA_W)+1 bits.
  - No wrap within a transfer.
- reset_n asserted mid-transfer: all outputs go to reset values immediately, no done pulse; ssn deasserts asynchronously.

Decomposition:
- Package spi_px_pkg holds:
  - state enum IDLE/SETUP/XFER/HOLD
  - mode encoding constants (MODE0..MODE3 as {cpol,cpha})
- Sub-module spi_px_clkgen:
  - half-period counter
  - emits lead_stb/trail_stb edge strobes and the sclk register
  - enable and cpol inputs
- Top level holds the FSM, shift register and ssn decode.

Test Plan:
- DATA_W=8, clk_div=0, mode 0, MSB-first, datain=8'hA5, miso looped to mosi, ss_sel=2 -> ssn=4'b1011 during transfer, dataout=8'hA5, done exactly 19 cycles after start, busy low afterwards.
- Mode 3 (cpol=1, cpha=1), clk_div=3, miso driven 8'h3C MSB-first on the falling edge, datain=8'h00 -> sclk idles high, edges every 4 cycles, dataout=8'h3C, mosi constant 0, done at cycle 73.
- lsb_first=1, mode 1, datain=8'h01, loopback -> first mosi bit 1 then zeros, dataout=8'h01. Same with lsb_first=0 -> mosi 1 appears on the last bit only.
- Second start pulsed while busy with datain=8'hFF -> ignored: mosi stream and dataout reflect the first word only, a single done pulse; a new start accepted in the done cycle runs a back-to-back transfer.
- reset_n low at XFER edge 5 -> ssn=all 1, sclk=0, busy=0, dataout=0 immediately, no done. After release, a fresh mode-0 transfer of 8'h5A loopback completes normally.
- ss_sel=3 with NUM_SS=3 -> ssn stays 3'b111, transfer and done timing unchanged.

Source files
------------

// File: rtl/spi_px_pkg.sv
// Shared types and mode helpers for the parametrised SPI master.
package spi_px_pkg;

    // Transfer phases of the master FSM.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // SPI mode encodings as {cpol, cpha}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // In modes 0 and 2 the leading SCLK edge is the sampling edge.
    function automatic logic samples_on_lead(input logic [1:0] mode);
        return (mode == MODE0) || (mode == MODE2);
    endfunction

    // In modes 1 and 3 data is advanced on the leading SCLK edge.
    function automatic logic shifts_on_lead(input logic [1:0] mode);
        return (mode == MODE1) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/spi_px_clkgen.sv
// SCLK generator: half-period counter, leading/trailing edge strobes and
// the registered sclk output.
module spi_px_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             en,
    input  logic             toggle,
    input  logic             cpol,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             lead_stb,
    output logic             trail_stb,
    output logic             sclk
);

    logic             armed;
    logic [DIV_W-1:0] cnt;

    // A tick marks the last cycle of each half period; the first enabled
    // cycle only arms the counter, which aligns the phases with completion.
    assign tick      = en && armed && (cnt == div);
    assign lead_stb  = tick && toggle && (sclk == cpol);
    assign trail_stb = tick && toggle && (sclk != cpol);

    // Half-period counter, cleared whenever the generator is disabled.
    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (!en) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // SCLK rests at cpol outside the shifting phase and toggles on each tick.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sclk <= 1'b0;
        end else if (!en || !toggle) begin
            sclk <= cpol;
        end else if (tick) begin
            sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_master_px.sv
// Parametrised SPI master: runtime mode, bit order and SCLK divider,
// one-hot active-low slave selects and a start/busy/done handshake.
module spi_master_px
    import spi_px_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int SS_W   = 2,
    parameter int DIV_W  = 8
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] datain,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic [DATA_W-1:0] dataout,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_SS-1:0] ssn
);

    localparam int              EC_W      = $clog2(2 * DATA_W) + 1;
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W - 1);

    state_t             state;
    logic [DATA_W-1:0]  sr;
    logic               rx_bit;
    logic [1:0]         mode_q;
    logic               lsb_q;
    logic [DIV_W-1:0]   div_q;
    logic [EC_W-1:0]    edge_cnt;

    logic [NUM_SS-1:0]  ssn_dec;
    logic               tick;
    logic               lead_stb;
    logic               trail_stb;
    logic               cpol_sel;
    logic               last_edge;
    logic               do_sample;
    logic               do_shift;
    logic [DATA_W-1:0]  sr_shifted;

    spi_px_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .en        (state != IDLE),
        .toggle    (state == XFER),
        .cpol      (cpol_sel),
        .div       (div_q),
        .tick      (tick),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .sclk      (sclk)
    );

    // One-hot active-low decode of the requested slave; out-of-range
    // indices leave every select deasserted.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ssn_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (int'(ss_sel) == i) ssn_dec[i] = 1'b0;
        end
    end

    // Edge classification and the next shift-register value; received bits
    // enter at the end opposite the transmit end.
    always_comb begin
        cpol_sel  = (state == IDLE) ? cpol : mode_q[1];
        last_edge = (edge_cnt == LAST_EDGE);
        do_sample = samples_on_lead(mode_q) ? lead_stb : trail_stb;
        do_shift  = shifts_on_lead(mode_q) ? (lead_stb && (edge_cnt != '0))
                                           : (trail_stb && !last_edge);
        if (lsb_q) begin
            sr_shifted = {rx_bit, sr[DATA_W-1:1]};
        end else begin
            sr_shifted = {sr[DATA_W-2:0], rx_bit};
        end
    end

    // Transfer FSM with registered handshake, mosi, ssn and dataout.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mosi     <= 1'b0;
            ssn      <= '1;
            dataout  <= '0;
            sr       <= '0;
            rx_bit   <= 1'b0;
            mode_q   <= MODE0;
            lsb_q    <= 1'b0;
            div_q    <= '0;
            edge_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        sr       <= datain;
                        mode_q   <= {cpol, cpha};
                        lsb_q    <= lsb_first;
                        div_q    <= clk_div;
                        ssn      <= ssn_dec;
                        mosi     <= lsb_first ? datain[0] : datain[DATA_W-1];
                        edge_cnt <= '0;
                        rx_bit   <= 1'b0;
                    end
                end
                SETUP: begin
                    if (tick) state <= XFER;
                end
                XFER: begin
                    if (do_sample) rx_bit <= miso;
                    if (do_shift) begin
                        sr   <= sr_shifted;
                        mosi <= lsb_q ? sr[1] : sr[DATA_W-2];
                    end
                    if (lead_stb || trail_stb) begin
                        edge_cnt <= edge_cnt + 1'b1;
                        if (last_edge) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        ssn     <= '1;
                        mosi    <= 1'b0;
                        // The final sample is still pending in rx_bit.
                        dataout <= sr_shifted;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_px.sv
// Self-checking bench for spi_master_px: a behavioural SPI slave sees the
// SCLK edges, drives miso and collects mosi for comparison.
module tb_spi_master_px;

    typedef struct {
        logic [7:0] w;
        logic [1:0] ss;
        logic       pol;
        logic       pha;
        logic       lsb;
        logic [7:0] div;
        logic [7:0] sw;
        logic       lb;
    } xfer_t;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] datain;
    logic [1:0] ss_sel;
    logic       cpol;
    logic       cpha;
    logic       lsb_first;
    logic [7:0] clk_div;
    logic       miso;
    logic       slave_miso;
    logic       loopback;

    logic [7:0] dataout, dataout3;
    logic       busy, busy3, done, done3, sclk, sclk3, mosi, mosi3;
    logic [3:0] ssn;
    logic [2:0] ssn3;

    int checks = 0;
    int errors = 0;

    assign miso = loopback ? mosi : slave_miso;

    always #5 clock_in = ~clock_in;

    spi_master_px dut (
        .clock_in (clock_in), .reset_n (reset_n), .start (start),
        .datain (datain), .ss_sel (ss_sel), .cpol (cpol), .cpha (cpha),
        .lsb_first (lsb_first), .clk_div (clk_div), .miso (miso),
        .dataout (dataout), .busy (busy), .done (done), .sclk (sclk),
        .mosi (mosi), .ssn (ssn)
    );

    spi_master_px #(.NUM_SS(3), .SS_W(2)) dut3 (
        .clock_in (clock_in), .reset_n (reset_n), .start (start),
        .datain (datain), .ss_sel (ss_sel), .cpol (cpol), .cpha (cpha),
        .lsb_first (lsb_first), .clk_div (clk_div), .miso (miso),
        .dataout (dataout3), .busy (busy3), .done (done3), .sclk (sclk3),
        .mosi (mosi3), .ssn (ssn3)
    );

    // Position of the k-th bit on the wire within the word.
    function automatic int bit_idx(input logic lsb, input int k);
        return lsb ? k : 7 - k;
    endfunction

    // Present a request; it is accepted on the next rising clock edge.
    task automatic start_xfer(input xfer_t x);
        datain     = x.w;
        ss_sel     = x.ss;
        cpol       = x.pol;
        cpha       = x.pha;
        lsb_first  = x.lsb;
        clk_div    = x.div;
        loopback   = x.lb;
        slave_miso = x.pha ? 1'b0 : x.sw[bit_idx(x.lsb, 0)];
        start      = 1'b1;
    endtask

    // Run the slave model until done (bounded) and check the whole transfer.
    task automatic wait_xfer(input xfer_t x, input bit disturb, input string name);
        int h, lat, cyc, nedge, last_cyc, gap_bad, hold_bad, d3_bad, k;
        bit seen;
        logic prev;
        logic [7:0] got, exp_rx;
        logic [3:0] exp_ssn;
        logic [2:0] exp_ssn3;
        h = int'(x.div) + 1;
        lat = (2 * 8 + 2) * h + 1;
        exp_rx = x.lb ? x.w : x.sw;
        exp_ssn = 4'hF;
        for (int i = 0; i < 4; i++) if (int'(x.ss) == i) exp_ssn[i] = 1'b0;
        exp_ssn3 = 3'h7;
        for (int i = 0; i < 3; i++) if (int'(x.ss) == i) exp_ssn3[i] = 1'b0;
        cyc = 0; nedge = 0; last_cyc = 0; gap_bad = 0; hold_bad = 0; d3_bad = 0;
        seen = 1'b0; got = 8'h00;

        @(posedge clock_in); #1;
        start = 1'b0;
        checks++;
        if (mosi !== x.w[bit_idx(x.lsb, 0)]) begin
            errors++; $display("FAIL %s first_mosi: got %b want %b", name, mosi, x.w[bit_idx(x.lsb, 0)]);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_on: got %b want 1", name, busy);
        end
        checks++;
        if (ssn !== exp_ssn || ssn3 !== exp_ssn3) begin
            errors++; $display("FAIL %s ssn: got %b/%b want %b/%b", name, ssn, ssn3, exp_ssn, exp_ssn3);
        end
        prev = sclk;

        while (!seen && cyc < lat + 8) begin
            @(posedge clock_in); #1;
            cyc++;
            start = 1'b0;
            if (done3 !== done) d3_bad++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (ssn !== exp_ssn || ssn3 !== exp_ssn3) hold_bad++;
                if (sclk !== prev) begin
                    nedge++;
                    if (nedge > 1 && (cyc - last_cyc) != h) gap_bad++;
                    last_cyc = cyc;
                    prev = sclk;
                    if (x.pha ? (nedge % 2 == 0) : (nedge % 2 == 1)) begin
                        k = x.pha ? nedge / 2 - 1 : (nedge - 1) / 2;
                        if (k >= 0 && k < 8) got[bit_idx(x.lsb, k)] = mosi;
                    end else begin
                        k = x.pha ? (nedge - 1) / 2 : nedge / 2;
                        if (k >= 0 && k < 8) slave_miso = x.sw[bit_idx(x.lsb, k)];
                    end
                    if (disturb && nedge == 4) begin
                        start     = 1'b1;
                        datain    = 8'hFF;
                        cpol      = ~x.pol;
                        cpha      = ~x.pha;
                        lsb_first = ~x.lsb;
                        clk_div   = x.div + 8'd3;
                        ss_sel    = x.ss + 2'd1;
                    end
                end
            end
        end

        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s timeout: no done after %0d cycles, want %0d", name, cyc, lat);
            return;
        end
        checks++;
        if (cyc != lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
        end
        checks++;
        if (nedge != 16 || gap_bad != 0) begin
            errors++; $display("FAIL %s sclk: edges %0d bad_gaps %0d want 16/0", name, nedge, gap_bad);
        end
        checks++;
        if (got !== x.w) begin
            errors++; $display("FAIL %s mosi_word: got %h want %h", name, got, x.w);
        end
        checks++;
        if (dataout !== exp_rx || dataout3 !== exp_rx) begin
            errors++; $display("FAIL %s dataout: got %h/%h want %h", name, dataout, dataout3, exp_rx);
        end
        checks++;
        if (busy !== 1'b0 || ssn !== 4'hF || ssn3 !== 3'h7 || sclk !== x.pol) begin
            errors++; $display("FAIL %s end_state: busy %b ssn %b ssn3 %b sclk %b want 0 1111 111 %b",
                               name, busy, ssn, ssn3, sclk, x.pol);
        end
        checks++;
        if (hold_bad != 0 || d3_bad != 0) begin
            errors++; $display("FAIL %s ssn_hold/done3: %0d/%0d bad cycles want 0/0", name, hold_bad, d3_bad);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; datain = 8'h00; ss_sel = 2'd0; cpol = 1'b1;
        cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0; slave_miso = 1'b0; loopback = 1'b0;
        repeat (3) @(posedge clock_in);
        #1;
        checks++;
        if (sclk !== 1'b0 || mosi !== 1'b0 || ssn !== 4'hF || dataout !== 8'h00 ||
            busy !== 1'b0 || done !== 1'b0 || ssn3 !== 3'h7) begin
            errors++; $display("FAIL reset_state: sclk %b mosi %b ssn %b dataout %h busy %b done %b",
                               sclk, mosi, ssn, dataout, busy, done);
        end
        @(negedge clock_in);
        reset_n = 1'b1;
        @(posedge clock_in); #1;
        checks++;
        if (sclk !== 1'b1) begin
            errors++; $display("FAIL idle_sclk_cpol1: got %b want 1", sclk);
        end
        cpol = 1'b0;
        @(posedge clock_in); #1;
        checks++;
        if (sclk !== 1'b0) begin
            errors++; $display("FAIL idle_sclk_cpol0: got %b want 0", sclk);
        end
    endtask

    task automatic test_mode0_loop();
        xfer_t x;
        x = '{w: 8'hA5, ss: 2'd2, pol: 1'b0, pha: 1'b0, lsb: 1'b0, div: 8'd0, sw: 8'h00, lb: 1'b1};
        start_xfer(x);
        wait_xfer(x, 1'b0, "mode0_loop");
    endtask

    task automatic test_mode3_slave();
        xfer_t x;
        x = '{w: 8'h00, ss: 2'd0, pol: 1'b1, pha: 1'b1, lsb: 1'b0, div: 8'd3, sw: 8'h3C, lb: 1'b0};
        start_xfer(x);
        wait_xfer(x, 1'b0, "mode3_slave");
    endtask

    task automatic test_bit_order();
        xfer_t x;
        x = '{w: 8'h01, ss: 2'd1, pol: 1'b0, pha: 1'b1, lsb: 1'b1, div: 8'd0, sw: 8'h00, lb: 1'b1};
        start_xfer(x);
        wait_xfer(x, 1'b0, "mode1_lsb");
        x.lsb = 1'b0;
        start_xfer(x);
        wait_xfer(x, 1'b0, "mode1_msb");
    endtask

    task automatic test_busy_ignore();
        xfer_t x;
        x = '{w: 8'h69, ss: 2'd3, pol: 1'b0, pha: 1'b0, lsb: 1'b0, div: 8'd1, sw: 8'h00, lb: 1'b1};
        start_xfer(x);
        wait_xfer(x, 1'b1, "busy_ignore");
        @(posedge clock_in); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dataout !== 8'h69) begin
            errors++; $display("FAIL busy_ignore_after: done %b busy %b dataout %h want 0 0 69", done, busy, dataout);
        end
    endtask

    task automatic test_back_to_back();
        xfer_t a, b;
        a = '{w: 8'hC3, ss: 2'd1, pol: 1'b1, pha: 1'b0, lsb: 1'b1, div: 8'd0, sw: 8'h00, lb: 1'b1};
        b = '{w: 8'h00, ss: 2'd0, pol: 1'b0, pha: 1'b1, lsb: 1'b0, div: 8'd2, sw: 8'h96, lb: 1'b0};
        start_xfer(a);
        wait_xfer(a, 1'b0, "b2b_first");
        start_xfer(b);
        wait_xfer(b, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        xfer_t x;
        int nedge;
        logic prev;
        bit done_seen;
        x = '{w: 8'hE7, ss: 2'd2, pol: 1'b0, pha: 1'b0, lsb: 1'b0, div: 8'd0, sw: 8'h00, lb: 1'b1};
        start_xfer(x);
        @(posedge clock_in); #1;
        start = 1'b0;
        prev = sclk;
        nedge = 0;
        for (int c = 0; c < 40 && nedge < 5; c++) begin
            @(posedge clock_in); #1;
            if (sclk !== prev) begin
                nedge++;
                prev = sclk;
            end
        end
        checks++;
        if (nedge != 5) begin
            errors++; $display("FAIL reset_mid_reach: edges %0d want 5", nedge);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ssn !== 4'hF || sclk !== 1'b0 || busy !== 1'b0 || dataout !== 8'h00 || mosi !== 1'b0) begin
            errors++; $display("FAIL reset_mid_state: ssn %b sclk %b busy %b dataout %h mosi %b",
                               ssn, sclk, busy, dataout, mosi);
        end
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge clock_in); #1;
            if (done !== 1'b0) done_seen = 1'b1;
        end
        @(negedge clock_in);
        reset_n = 1'b1;
        repeat (25) begin
            @(posedge clock_in); #1;
            if (done !== 1'b0) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++; $display("FAIL reset_mid_no_done: got a done pulse want none");
        end
        x = '{w: 8'h5A, ss: 2'd0, pol: 1'b0, pha: 1'b0, lsb: 1'b0, div: 8'd0, sw: 8'h00, lb: 1'b1};
        start_xfer(x);
        wait_xfer(x, 1'b0, "after_reset");
    endtask

    task automatic test_ss_out_of_range();
        xfer_t x;
        x = '{w: 8'h4D, ss: 2'd3, pol: 1'b1, pha: 1'b0, lsb: 1'b0, div: 8'd2, sw: 8'hB2, lb: 1'b0};
        start_xfer(x);
        wait_xfer(x, 1'b0, "ss_out_of_range");
    endtask

    task automatic test_random();
        xfer_t x;
        for (int n = 0; n < 8; n++) begin
            x.w   = 8'($urandom);
            x.ss  = 2'($urandom_range(0, 3));
            x.pol = 1'($urandom_range(0, 1));
            x.pha = 1'($urandom_range(0, 1));
            x.lsb = 1'($urandom_range(0, 1));
            x.div = 8'($urandom_range(0, 3));
            x.sw  = 8'($urandom);
            x.lb  = 1'($urandom_range(0, 1));
            start_xfer(x);
            wait_xfer(x, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_mode0_loop();
        test_mode3_slave();
        test_bit_order();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_ss_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
